// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the dm two-port arbiter/sequencer.
package dm_arb_pkg;

  localparam int ID_W = 1;

  localparam logic [3:0] BE_FULL = 4'hF;
  localparam logic [3:0] BE_NONE = 4'h0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2
  } arb_state_e;

  typedef logic [ID_W-1:0] req_id_t;

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester-side bundle of the dm arbiter: both request ports plus their completions.
interface dm_arbiter_if #(
  parameter int ADDR_W = 32
);

  // Handshake: req[i] is a valid that the requester holds, with we/addr/wdata/be
  // stable, until the arbiter pulses ack[i] for exactly one cycle. ack is the
  // only "ready"; a req still high in the cycle after ack is a new request.
  logic [1:0]        req;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [31:0]       wdata0;
  logic [31:0]       wdata1;
  logic [3:0]        be0;
  logic [3:0]        be1;
  logic [1:0]        ack;
  logic [31:0]       rdata0;
  logic [31:0]       rdata1;

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, be0, be1,
    input  ack, rdata0, rdata1
  );

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, be0, be1,
    output ack, rdata0, rdata1
  );

endinterface

// File: rtl/dm_be_merge.sv
// Byte-lane merge of new store data into the old memory word for partial writes.
module dm_be_merge (
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  input  logic [31:0] old,
  output logic [31:0] merged
);

  always_comb begin
    merged = old;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) merged[8*k +: 8] = wdata[8*k +: 8];
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter for the single-port data memory; partial stores run as a
// registered read-modify-write because dm has no byte enables.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              Reset,
  dm_arbiter_if.slave       bus,
  output logic [ADDR_W-1:0] dm_A,
  output logic [31:0]       dm_WD,
  output logic              dm_WE,
  output logic              dm_RE,
  input  logic [31:0]       dm_RD,
  output arb_state_e        dbg_state
);

  arb_state_e        state;
  req_id_t           cmd_id;
  req_id_t           last;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic [3:0]        cmd_be;
  logic              cmd_we;
  logic [31:0]       merge_q;
  logic [31:0]       merged;

  logic [1:0]        elig;
  logic              grant_valid;
  req_id_t           grant_id;

  // A request whose ack is on the wire this cycle is not re-granted yet.
  assign elig = bus.req & ~bus.ack;

  always_comb begin
    grant_valid = |elig;
    grant_id    = '0;
    if (elig == 2'b11) grant_id = ~last;
    else if (elig[1])  grant_id = 1'b1;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      cmd_id     <= '0;
      last       <= 1'b1;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      cmd_be     <= '0;
      cmd_we     <= 1'b0;
      merge_q    <= '0;
      bus.ack    <= '0;
      bus.rdata0 <= '0;
      bus.rdata1 <= '0;
    end else begin
      bus.ack <= '0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            cmd_id <= grant_id;
            last   <= grant_id;
            cmd_we <= bus.we[grant_id];
            if (grant_id == 1'b0) begin
              cmd_addr  <= bus.addr0;
              cmd_wdata <= bus.wdata0;
              cmd_be    <= bus.be0;
            end else begin
              cmd_addr  <= bus.addr1;
              cmd_wdata <= bus.wdata1;
              cmd_be    <= bus.be1;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!cmd_we) begin
            if (cmd_id == 1'b0) bus.rdata0 <= dm_RD;
            else                bus.rdata1 <= dm_RD;
            bus.ack[cmd_id] <= 1'b1;
            state           <= IDLE;
          end else if (cmd_be == BE_FULL || cmd_be == BE_NONE) begin
            bus.ack[cmd_id] <= 1'b1;
            state           <= IDLE;
          end else begin
            // Capture the old word; the merged write goes out next cycle.
            merge_q <= dm_RD;
            state   <= MERGE;
          end
        end
        MERGE: begin
          bus.ack[cmd_id] <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  dm_be_merge u_merge (
    .be     (cmd_be),
    .wdata  (cmd_wdata),
    .old    (merge_q),
    .merged (merged)
  );

  // Memory strobes come from state alone, so reset kills dm_WE immediately.
  always_comb begin
    dm_A  = cmd_addr;
    dm_WD = cmd_wdata;
    dm_WE = 1'b0;
    dm_RE = 1'b0;
    case (state)
      ACCESS: begin
        dm_RE = ~cmd_we;
        dm_WE = cmd_we && (cmd_be == BE_FULL);
      end
      MERGE: begin
        dm_WE = 1'b1;
        dm_WD = merged;
      end
      default: ;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and sequencer for the single-port data memory `dm`. Requester 0 is the pipeline M-stage load/store port and requester 1 is the debug/DMA bridge. The block grants `dm` round-robin and performs word reads and word writes directly. Because `dm` has no byte enables, partial-word stores are executed as a registered read-modify-write. It sits between the M-stage and `dm`, and its `dm_*` outputs drive `dm`'s `A`/`WD`/`WE`/`RE` ports.

## Interface
- `ADDR_W`, default 32: address width passed through to `dm_A`.
- `clk`  in  1  system clock, rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `req[1:0]`  in  2  per-requester request; held with its command fields until `ack`.
- `we[1:0]`  in  2  per-requester write (1) / read (0).
- `addr0`, `addr1`  in  ADDR_W  byte address; bits [1:0] ignored for `dm` indexing.
- `wdata0`, `wdata1`  in  32  lane-aligned store data (byte k in bits [8k+7:8k]).
- `be0`, `be1`  in  4  byte enables for writes; ignored for reads.
- `ack[1:0]`  out  2  one-cycle completion pulse, registered.
- `rdata0`, `rdata1`  out  32  registered read word; valid when the matching `ack` is high, then held.
- `dm_A`  out  ADDR_W  memory address.
- `dm_WD`  out  32  memory write data.
- `dm_WE`  out  1  memory write enable.
- `dm_RE`  out  1  memory read enable.
- `dm_RD`  in  32  memory combinational read data.

## Operation
- States: IDLE, ACCESS, MERGE.
- **IDLE**
  - Eligible requesters are `req[i] & ~ack[i]`. Masking by `ack` prevents re-granting a request the requester has not yet dropped.
  - One eligible requester: grant it.
  - Two eligible requesters: grant the one not equal to `last`.
  - On grant: latch `id`, `addr`, `wdata`, `be` and `we` into command registers, set `last <= id`, go to ACCESS.
- **ACCESS**
  - `dm_A` = command address. `dm_RE` = ~cmd_we.
  - Read: `rdata[id] <= dm_RD`, `ack[id] <= 1`, go to IDLE.
  - Write with `be == 4'hF`: `dm_WE = 1`, `dm_WD = wdata`, `ack[id] <= 1`, go to IDLE.
  - Write with `be == 4'h0`: no memory write, `ack[id] <= 1`, go to IDLE.
  - Any other `be`: `merge <= dm_RD`, go to MERGE.
- **MERGE**
  - `dm_WE = 1`.
  - `dm_WD[8k+7:8k] = be[k] ? wdata[8k+7:8k] : merge[8k+7:8k]`.
  - `ack[id] <= 1`, go to IDLE.
- Output decoding:
  - `dm_WE`, `dm_RE`, `dm_A` and `dm_WD` are decoded from state and command registers only. They never depend combinationally on `req`.
  - `dm_WE = 0` and `dm_RE = 0` in IDLE.
  - `ack` is cleared every cycle unless it is being set.
- Reset values: state IDLE, `ack = 0`, `rdata0 = rdata1 = 0`, `last = 1` (so requester 0 wins the first tie), command and merge registers 0.

## Timing
- Word read or write: `req` sampled at edge E0; `dm` access in cycle E0–E1; `ack` high in cycle E1–E2. Two cycles from `req` to `ack`.
- Partial write: ACCESS in E0–E1, MERGE write in E1–E2, `ack` in E2–E3. Three cycles.
- Back-to-back: the other requester may be granted in the same cycle `ack` is high. Sustained word throughput for alternating requesters is one operation per two cycles.
- A requester whose `req` is still high in its `ack` cycle is not re-granted that cycle. If `req` is still high the following cycle, it is a new request.
- Simultaneous requests: strict alternation by `last`; neither requester starves.
- Reset asserted mid-operation: immediate abort and return to IDLE. `dm_WE` drops asynchronously and no partial write completes. The aborted requester receives no `ack`.
- Request fields changing while `req` is held and not yet acked are a protocol violation. The latched copy is used.

## Structure
- Package `dm_arb_pkg`:
  - State enum `{IDLE, ACCESS, MERGE}`.
  - Constants `BE_FULL = 4'hF`, `BE_NONE = 4'h0`.
  - Requester id width (1).
- Sub-module `dm_be_merge`: combinational, with inputs `be`, `wdata`, `old` and output `merged`. Used for `dm_WD` in MERGE.
- `dm` itself is instantiated outside the block.

## Test plan
- Reset then single read: preload `dm[3] = 32'hDEADBEEF`; `req0`, `addr0 = 32'hC`, `we0 = 0` → `ack0` two cycles later, `rdata0 = 32'hDEADBEEF`, `dm_WE` never high.
- Partial write: `dm[4] = 32'h11223344`; req1 write `addr1 = 32'h10`, `be1 = 4'b0010`, `wdata1 = 32'h0000AB00` → `dm_WE` only in the MERGE cycle with `dm_WD = 32'h1122AB44`, `ack1` at cycle 3.
- Simultaneous requests: both `req` high continuously, word writes → grants alternate 0,1,0,1 starting with 0, each `ack` two cycles apart and one-hot.
- Held `req`: `req0` kept high one cycle past `ack0` with `req1` low → no grant in the `ack0` cycle, new grant the next cycle.
- `be = 4'h0` write: `ack` after two cycles, `dm_WE` stays 0, memory unchanged.
- Reset mid-MERGE: assert `Reset` low during MERGE → `dm_WE` falls immediately, no `ack`, target word keeps its old value, `rdata0`/`rdata1` read 0.
